keyword_tokenizer: RTL and testbench

//  Upstream stage of the block-nesting checker. Consumes a raw ASCII character stream, splits it into words
//  and classifies each word case-insensitively as BEGIN / END / OTHER.

---
 rtl/keyword_tok_pkg.sv | 77 +++++++
 rtl/tok_fifo.sv | 75 +++++++
 rtl/keyword_tokenizer.sv | 115 +++++++++++
 tb/tb_keyword_tokenizer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keyword_tok_pkg.sv
// Shared definitions for the keyword tokenizer: token codes, matcher states,
// ASCII constants and small character-classification helpers.
package keyword_tok_pkg;

   // Token classification codes as they appear on tok_type
   typedef enum logic [1:0] {
      TOK_NONE  = 2'b00,
      TOK_BEGIN = 2'b01,
      TOK_END   = 2'b10,
      TOK_OTHER = 2'b11
   } tokType_e;

   // Matcher states: prefixes of "begin" and "end", full matches, and a catch-all
   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_B1       = 4'd1,
      ST_B2       = 4'd2,
      ST_B3       = 4'd3,
      ST_B4       = 4'd4,
      ST_BEGIN_OK = 4'd5,
      ST_E1       = 4'd6,
      ST_E2       = 4'd7,
      ST_END_OK   = 4'd8,
      ST_OTHER    = 4'd9
   } matchState_e;

   localparam logic [7:0] ASCII_SPACE   = 8'h20;
   localparam logic [7:0] ASCII_UPPER_A = 8'h41;
   localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;
   localparam logic [7:0] ASCII_CASE    = 8'h20;

   // Upper-case letters get the case bit set; everything else passes untouched
   function automatic logic [7:0] foldCase(input logic [7:0] c);
      if (c >= ASCII_UPPER_A && c <= ASCII_UPPER_Z) begin
         return c | ASCII_CASE;
      end
      return c;
   endfunction

   // True for [A-Za-z0-9_]; only consulted when punctuation delimits words
   function automatic logic isWordChar(input logic [7:0] c);
      return (c >= 8'h61 && c <= 8'h7A) ||
             (c >= 8'h41 && c <= 8'h5A) ||
             (c >= 8'h30 && c <= 8'h39) ||
             (c == 8'h5F);
   endfunction

   // One step of the keyword matcher for a lower-cased, non-delimiter character
   function automatic matchState_e matchStep(input matchState_e s, input logic [7:0] c);
      matchState_e n;
      n = ST_OTHER;
      case (s)
         ST_IDLE: begin
            if (c == "b") n = ST_B1;
            else if (c == "e") n = ST_E1;
         end
         ST_B1:   if (c == "e") n = ST_B2;
         ST_B2:   if (c == "g") n = ST_B3;
         ST_B3:   if (c == "i") n = ST_B4;
         ST_B4:   if (c == "n") n = ST_BEGIN_OK;
         ST_E1:   if (c == "n") n = ST_E2;
         ST_E2:   if (c == "d") n = ST_END_OK;
         default: n = ST_OTHER;
      endcase
      return n;
   endfunction

   // Token type produced when a word ends while the matcher sits in state s
   function automatic tokType_e stateToken(input matchState_e s);
      case (s)
         ST_BEGIN_OK: return TOK_BEGIN;
         ST_END_OK:   return TOK_END;
         default:     return TOK_OTHER;
      endcase
   endfunction

endpackage

// File: rtl/tok_fifo.sv
// Synchronous token FIFO with registered head outputs (first word falls
// through one cycle after the push) and a registered write-ready.
module tok_fifo
   import keyword_tok_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] pushData_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic             wrReady_o,
   output logic [WIDTH-1:0] headData_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
   logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] occAfterPop;
   logic [WIDTH-1:0] headData_q, headData_d;
   logic             wrReady_q;
   logic             doPush;
   logic             doPop;

   // Next pointers, occupancy and the value the head register must show next cycle.
   // If the queue would be empty after this pop, the head comes straight from the push.
   always_comb begin
      doPush      = push_i && (count_q != DEPTH_CNT);
      doPop       = pop_i && (count_q != '0);
      rdPtr_d     = doPop  ? rdPtr_q + PTR_W'(1) : rdPtr_q;
      wrPtr_d     = doPush ? wrPtr_q + PTR_W'(1) : wrPtr_q;
      occAfterPop = count_q - CNT_W'(doPop);
      count_d     = occAfterPop + CNT_W'(doPush);
      headData_d  = (occAfterPop == '0) ? pushData_i : mem_q[rdPtr_d];
   end

   // Storage array; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (doPush) begin
         mem_q[wrPtr_q] <= pushData_i;
      end
   end

   // Pointers, count, head register and write-ready, cleared by reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdPtr_q    <= '0;
         wrPtr_q    <= '0;
         count_q    <= '0;
         headData_q <= '0;
         wrReady_q  <= 1'b0;
      end else begin
         rdPtr_q    <= rdPtr_d;
         wrPtr_q    <= wrPtr_d;
         count_q    <= count_d;
         headData_q <= headData_d;
         wrReady_q  <= (count_d != DEPTH_CNT);
      end
   end

   assign full_o     = (count_q == DEPTH_CNT);
   assign empty_o    = (count_q == '0);
   assign wrReady_o  = wrReady_q;
   assign headData_o = headData_q;

endmodule

// File: rtl/keyword_tokenizer.sv
// Keyword tokenizer top: folds case, splits the character stream into words,
// classifies each word as BEGIN / END / OTHER and queues tokens in tok_fifo.
// Build option: define KEYWORD_TOK_PUNCT_DELIM_EN to treat every character
// outside [A-Za-z0-9_] as a delimiter; otherwise only space delimits.
module keyword_tokenizer
   import keyword_tok_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int LEN_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       in,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic             tok_valid,
   output logic [1:0]       tok_type,
   output logic [LEN_W-1:0] tok_len,
   input  logic             tok_ready
);

   localparam int TOK_W = 2 + LEN_W;
   localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

   matchState_e      state_q;
   logic [LEN_W-1:0] lenCount_q;

   logic [7:0]       charLower;
   logic             isDelim;
   logic             accept;
   matchState_e      stepState;
   logic [LEN_W-1:0] lenInc;
   logic             pushValid;
   tokType_e         pushType;
   logic [LEN_W-1:0] pushLen;
   logic [TOK_W-1:0] pushData;

   logic             fifoFull;
   logic             fifoEmpty;
   logic             fifoReady;
   logic             popReq;
   logic [TOK_W-1:0] headData;

   // Character classification, matcher lookahead and the push decision for this cycle.
   // A word ends on an accepted delimiter (if a word is open) or on an accepted
   // non-delimiter flagged last, in which case that character belongs to the word.
   always_comb begin
      charLower = foldCase(in);
`ifdef KEYWORD_TOK_PUNCT_DELIM_EN
      isDelim   = !isWordChar(charLower);
`else
      isDelim   = (in == ASCII_SPACE);
`endif
      accept    = in_valid && fifoReady && !fifoFull;
      stepState = matchStep(state_q, charLower);
      lenInc    = (lenCount_q == LEN_MAX) ? lenCount_q : lenCount_q + LEN_W'(1);
      pushValid = 1'b0;
      pushType  = TOK_NONE;
      pushLen   = '0;
      if (accept) begin
         if (isDelim) begin
            if (state_q != ST_IDLE) begin
               pushValid = 1'b1;
               pushType  = stateToken(state_q);
               pushLen   = lenCount_q;
            end
         end else if (in_last) begin
            pushValid = 1'b1;
            pushType  = stateToken(stepState);
            pushLen   = lenInc;
         end
      end
      pushData = {pushType, pushLen};
   end

   // Matcher FSM and saturating length counter; both hold whenever no character is accepted
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         lenCount_q <= '0;
      end else if (accept) begin
         if (isDelim || in_last) begin
            state_q    <= ST_IDLE;
            lenCount_q <= '0;
         end else begin
            state_q    <= stepState;
            lenCount_q <= lenInc;
         end
      end
   end

   assign popReq = tok_ready && !fifoEmpty;

   tok_fifo #(
      .WIDTH (TOK_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (pushValid),
      .pushData_i (pushData),
      .pop_i      (popReq),
      .full_o     (fifoFull),
      .empty_o    (fifoEmpty),
      .wrReady_o  (fifoReady),
      .headData_o (headData)
   );

   assign in_ready  = fifoReady;
   assign tok_valid = !fifoEmpty;
   assign tok_type  = headData[TOK_W-1 -: 2];
   assign tok_len   = headData[LEN_W-1:0];

endmodule

// File: tb/tb_keyword_tokenizer.sv
// Directed testbench for keyword_tokenizer: drives character strings and
// compares the captured token stream against hand-computed expectations.
module tb_keyword_tokenizer;

   localparam logic [1:0] T_BEGIN = 2'b01;
   localparam logic [1:0] T_END   = 2'b10;
   localparam logic [1:0] T_OTHER = 2'b11;

   logic       clk;
   logic       reset;
   logic [7:0] inChar;
   logic       inValid;
   logic       inLast;
   logic       inReady;
   logic       tokValid;
   logic [1:0] tokType;
   logic [7:0] tokLen;
   logic       tokReady;

   int checks   = 0;
   int failures = 0;

   logic [1:0] gotType[$];
   logic [7:0] gotLen[$];

   keyword_tokenizer #(
      .FIFO_DEPTH (4),
      .LEN_W      (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in        (inChar),
      .in_valid  (inValid),
      .in_last   (inLast),
      .in_ready  (inReady),
      .tok_valid (tokValid),
      .tok_type  (tokType),
      .tok_len   (tokLen),
      .tok_ready (tokReady)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Capture every token handshake, sampled mid-cycle while inputs are stable
   always @(negedge clk) begin
      if (!reset && tokValid && tokReady) begin
         gotType.push_back(tokType);
         gotLen.push_back(tokLen);
      end
   end

   // Hard stop in case something stalls forever
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic clearCapture();
      gotType.delete();
      gotLen.delete();
   endtask

   // Present one character and hold it until the handshake completes
   task automatic sendChar(input logic [7:0] c, input logic last);
      int  waitCycles;
      logic done;
      waitCycles = 0;
      done       = 1'b0;
      inChar  = c;
      inValid = 1'b1;
      inLast  = last;
      while (!done) begin
         @(negedge clk);
         done = inReady;
         @(posedge clk);
         #2;
         if (!done) begin
            waitCycles++;
            if (waitCycles > 40) begin
               checks++;
               failures++;
               $display("[TB] FAIL handshake_timeout: char %02h not accepted after %0d cycles", c, waitCycles);
               done = 1'b1;
            end
         end
      end
      inValid = 1'b0;
      inLast  = 1'b0;
   endtask

   task automatic sendString(input string s, input logic lastOnFinal);
      for (int i = 0; i < s.len(); i++) begin
         sendChar(s[i], lastOnFinal && (i == s.len() - 1));
      end
   endtask

   // Reset values, in_ready low during reset and high one cycle after release
   task automatic test_reset();
      checks++;
      if (inReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 0", inReady); end
      checks++;
      if (tokValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_tok_valid: got %b expected 0", tokValid); end
      checks++;
      if (tokType !== 2'b00) begin failures++; $display("[TB] FAIL reset_tok_type: got %b expected 00", tokType); end
      checks++;
      if (tokLen !== 8'd0) begin failures++; $display("[TB] FAIL reset_tok_len: got %0d expected 0", tokLen); end
      reset = 1'b0;
      #1;
      checks++;
      if (inReady !== 1'b0) begin failures++; $display("[TB] FAIL release_in_ready_early: got %b expected 0", inReady); end
      @(posedge clk);
      #2;
      checks++;
      if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL release_in_ready: got %b expected 1", inReady); end
   endtask

   // Mixed-case keywords separated by single spaces
   task automatic test_case_fold();
      logic [1:0] expType[2] = '{T_BEGIN, T_END};
      logic [7:0] expLen[2]  = '{8'd5, 8'd3};
      tokReady = 1'b1;
      clearCapture();
      sendString("bEgin end ", 1'b0);
      idle(4);
      checks++;
      if (gotType.size() != 2) begin failures++; $display("[TB] FAIL case_fold_count: got %0d expected 2", gotType.size()); end
      for (int i = 0; i < 2 && i < gotType.size(); i++) begin
         checks++;
         if (gotType[i] !== expType[i] || gotLen[i] !== expLen[i]) begin
            failures++;
            $display("[TB] FAIL case_fold_tok%0d: got type %b len %0d expected type %b len %0d", i, gotType[i], gotLen[i], expType[i], expLen[i]);
         end
      end
   endtask

   // Leading, trailing and repeated spaces produce no empty tokens
   task automatic test_spaces();
      tokReady = 1'b1;
      clearCapture();
      sendString("  end  ", 1'b0);
      idle(4);
      checks++;
      if (gotType.size() != 1) begin failures++; $display("[TB] FAIL spaces_count: got %0d expected 1", gotType.size()); end
      if (gotType.size() >= 1) begin
         checks++;
         if (gotType[0] !== T_END || gotLen[0] !== 8'd3) begin
            failures++;
            $display("[TB] FAIL spaces_tok: got type %b len %0d expected type %b len 3", gotType[0], gotLen[0], T_END);
         end
      end
   endtask

   // Near-misses of keywords, a lone prefix letter, and punctuation glued to a keyword
   task automatic test_other_words();
      logic [1:0] expType[4] = '{T_OTHER, T_OTHER, T_OTHER, T_OTHER};
      logic [7:0] expLen[4]  = '{8'd4, 8'd6, 8'd1, 8'd4};
      tokReady = 1'b1;
      clearCapture();
      sendString("endA beginx e end; ", 1'b0);
      idle(4);
      checks++;
      if (gotType.size() != 4) begin failures++; $display("[TB] FAIL other_count: got %0d expected 4", gotType.size()); end
      for (int i = 0; i < 4 && i < gotType.size(); i++) begin
         checks++;
         if (gotType[i] !== expType[i] || gotLen[i] !== expLen[i]) begin
            failures++;
            $display("[TB] FAIL other_tok%0d: got type %b len %0d expected type %b len %0d", i, gotType[i], gotLen[i], expType[i], expLen[i]);
         end
      end
   endtask

   // in_last on the final letter emits the word at that handshake
   task automatic test_in_last();
      tokReady = 1'b1;
      clearCapture();
      sendString("en", 1'b0);
      checks++;
      if (tokValid !== 1'b0) begin failures++; $display("[TB] FAIL last_early_valid: got %b expected 0", tokValid); end
      sendChar("d", 1'b1);
      checks++;
      if (tokValid !== 1'b1 || tokType !== T_END || tokLen !== 8'd3) begin
         failures++;
         $display("[TB] FAIL last_head: got valid %b type %b len %0d expected valid 1 type %b len 3", tokValid, tokType, tokLen, T_END);
      end
      idle(3);
      checks++;
      if (gotType.size() != 1) begin failures++; $display("[TB] FAIL last_count: got %0d expected 1", gotType.size()); end
   endtask

   // A word longer than the length field reports the saturated maximum
   task automatic test_saturation();
      tokReady = 1'b1;
      clearCapture();
      for (int i = 0; i < 260; i++) begin
         sendChar("x", 1'b0);
      end
      sendChar(" ", 1'b0);
      idle(3);
      checks++;
      if (gotType.size() != 1) begin failures++; $display("[TB] FAIL sat_count: got %0d expected 1", gotType.size()); end
      if (gotType.size() >= 1) begin
         checks++;
         if (gotType[0] !== T_OTHER || gotLen[0] !== 8'd255) begin
            failures++;
            $display("[TB] FAIL sat_tok: got type %b len %0d expected type %b len 255", gotType[0], gotLen[0], T_OTHER);
         end
      end
   endtask

   // Fill the FIFO with the consumer stalled, hold a char, then drain in order
   task automatic test_back_to_back();
      logic [7:0] expLen[5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1};
      tokReady = 1'b0;
      clearCapture();
      sendString("a bb ccc dddd", 1'b0);
      checks++;
      if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL full_ready_before: got %b expected 1", inReady); end
      sendChar(" ", 1'b0);
      checks++;
      if (inReady !== 1'b0) begin failures++; $display("[TB] FAIL full_ready_after: got %b expected 0", inReady); end
      inChar  = "e";
      inValid = 1'b1;
      idle(3);
      checks++;
      if (inReady !== 1'b0 || tokValid !== 1'b1 || tokType !== T_OTHER || tokLen !== 8'd1) begin
         failures++;
         $display("[TB] FAIL full_hold: got ready %b valid %b type %b len %0d expected ready 0 valid 1 type %b len 1", inReady, tokValid, tokType, tokLen, T_OTHER);
      end
      tokReady = 1'b1;
      sendChar("e", 1'b0);
      sendChar(" ", 1'b0);
      idle(8);
      checks++;
      if (gotType.size() != 5) begin failures++; $display("[TB] FAIL drain_count: got %0d expected 5", gotType.size()); end
      for (int i = 0; i < 5 && i < gotType.size(); i++) begin
         checks++;
         if (gotType[i] !== T_OTHER || gotLen[i] !== expLen[i]) begin
            failures++;
            $display("[TB] FAIL drain_tok%0d: got type %b len %0d expected type %b len %0d", i, gotType[i], gotLen[i], T_OTHER, expLen[i]);
         end
      end
   endtask

   // Reset in the middle of a word with tokens queued discards everything
   task automatic test_reset_mid_word();
      tokReady = 1'b0;
      clearCapture();
      sendString("x y beg", 1'b0);
      checks++;
      if (tokValid !== 1'b1) begin failures++; $display("[TB] FAIL midreset_queued: got %b expected 1", tokValid); end
      reset = 1'b1;
      #1;
      checks++;
      if (tokValid !== 1'b0 || inReady !== 1'b0) begin
         failures++;
         $display("[TB] FAIL midreset_async: got valid %b ready %b expected valid 0 ready 0", tokValid, inReady);
      end
      idle(1);
      reset = 1'b0;
      idle(1);
      tokReady = 1'b1;
      clearCapture();
      sendString(" end ", 1'b0);
      idle(4);
      checks++;
      if (gotType.size() != 1) begin failures++; $display("[TB] FAIL midreset_count: got %0d expected 1", gotType.size()); end
      if (gotType.size() >= 1) begin
         checks++;
         if (gotType[0] !== T_END || gotLen[0] !== 8'd3) begin
            failures++;
            $display("[TB] FAIL midreset_tok: got type %b len %0d expected type %b len 3", gotType[0], gotLen[0], T_END);
         end
      end
   endtask

   // Test sequence
   initial begin
      reset    = 1'b1;
      inChar   = 8'h00;
      inValid  = 1'b0;
      inLast   = 1'b0;
      tokReady = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      $display("[TB] starting keyword_tokenizer tests");
      test_reset();
      test_case_fold();
      test_spaces();
      test_other_words();
      test_in_last();
      test_saturation();
      test_back_to_back();
      test_reset_mid_word();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
